// File: rtl/hy_stream_source.sv
// Register-file stimulus source for x_calculate: holds one 4x4 H and one 8-entry Y,
// then replays them as NUM_Q detection passes, each handshaked by q_done.
module hy_stream_source #(
  parameter int N       = 32,
  parameter int NUM_Q   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_valid,
  input  logic         ld_sel,
  input  logic [3:0]   ld_addr,
  input  logic [N-1:0] ld_r,
  input  logic [N-1:0] ld_i,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         start_new_q,
  output logic [3:0]   q_index,
  output logic         H_in_valid,
  output logic [N-1:0] H_in_r,
  output logic [N-1:0] H_in_i,
  output logic         Y_in_valid,
  output logic [N-1:0] Y_in_r,
  output logic [N-1:0] Y_in_i,
  input  logic         q_done
);

  localparam int               WW       = $clog2(TIMEOUT + 1);
  localparam logic [3:0]       LAST_Q   = 4'(NUM_Q - 1);
  localparam logic [WW-1:0]    WAIT_MAX = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_STREAM,
    S_WAIT
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [3:0]     r_pass, w_pass_nxt;
  logic [3:0]     r_beat, w_beat_nxt;
  logic [WW-1:0]  r_wait;
  logic           r_pend;
  logic           r_err;
  logic           w_hit;
  logic           w_timeout;
  logic           w_done;
  logic           w_h_on;
  logic           w_y_on;

  logic [N-1:0]   r_mem_h_r [16];
  logic [N-1:0]   r_mem_h_i [16];
  logic [N-1:0]   r_mem_y_r [8];
  logic [N-1:0]   r_mem_y_i [8];

  logic           r_h_valid;
  logic [N-1:0]   r_h_r, r_h_i;
  logic           r_y_valid;
  logic [N-1:0]   r_y_r, r_y_i;

  always_ff @(posedge clk) begin
    if (ld_valid && r_state == S_IDLE) begin
      if (!ld_sel) begin
        r_mem_h_r[ld_addr] <= ld_r;
        r_mem_h_i[ld_addr] <= ld_i;
      end else if (!ld_addr[3]) begin
        r_mem_y_r[ld_addr[2:0]] <= ld_r;
        r_mem_y_i[ld_addr[2:0]] <= ld_i;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pass_nxt  = r_pass;
    w_beat_nxt  = r_beat;
    w_hit       = r_pend | q_done;
    w_timeout   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ISSUE;
          w_pass_nxt  = '0;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_STREAM;
        w_beat_nxt  = '0;
      end
      S_STREAM: begin
        if (r_beat == 4'd15) begin
          w_state_nxt = S_WAIT;
          w_beat_nxt  = '0;
        end else begin
          w_beat_nxt  = r_beat + 4'd1;
        end
      end
      S_WAIT: begin
        // A completion seen on the final wait cycle wins over the timeout.
        if (w_hit) begin
          if (r_pass == LAST_Q) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
            w_pass_nxt  = '0;
          end else begin
            w_state_nxt = S_ISSUE;
            w_pass_nxt  = r_pass + 4'd1;
          end
        end else if (r_wait == WAIT_MAX) begin
          w_timeout   = 1'b1;
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
          w_pass_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pass_nxt  = '0;
        w_beat_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pass  <= '0;
      r_beat  <= '0;
      r_wait  <= '0;
      r_pend  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pass  <= w_pass_nxt;
      r_beat  <= w_beat_nxt;
      r_wait  <= (r_state == S_WAIT) ? r_wait + WW'(1) : '0;
      if (w_state_nxt == S_ISSUE && r_state != S_ISSUE) begin
        r_pend <= 1'b0;
      end else if (r_state != S_IDLE) begin
        r_pend <= r_pend | q_done;
      end
      if (r_state == S_IDLE && start) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  // Beat outputs are registered from the next-state view so beat b lines up with STREAM cycle b.
  assign w_h_on = (w_state_nxt == S_STREAM);
  assign w_y_on = w_h_on && !w_beat_nxt[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_valid <= 1'b0;
      r_h_r     <= '0;
      r_h_i     <= '0;
      r_y_valid <= 1'b0;
      r_y_r     <= '0;
      r_y_i     <= '0;
    end else begin
      r_h_valid <= w_h_on;
      r_h_r     <= w_h_on ? r_mem_h_r[w_beat_nxt] : '0;
      r_h_i     <= w_h_on ? r_mem_h_i[w_beat_nxt] : '0;
      r_y_valid <= w_y_on;
      r_y_r     <= w_y_on ? r_mem_y_r[w_beat_nxt[2:0]] : '0;
      r_y_i     <= w_y_on ? r_mem_y_i[w_beat_nxt[2:0]] : '0;
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = w_done;
  assign err         = r_err | w_timeout;
  assign start_new_q = (r_state == S_ISSUE);
  assign q_index     = r_pass;
  assign H_in_valid  = r_h_valid;
  assign H_in_r      = r_h_r;
  assign H_in_i      = r_h_i;
  assign Y_in_valid  = r_y_valid;
  assign Y_in_r      = r_y_r;
  assign Y_in_i      = r_y_i;

endmodule

// File: tb/tb_hy_stream_source.sv
// Directed bench for hy_stream_source: full 16-pass run, early q_done, busy loads,
// timeout abort, load+start in one cycle and asynchronous reset mid-stream.
module tb_hy_stream_source;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         ld_valid;
  logic         ld_sel;
  logic [3:0]   ld_addr;
  logic [N-1:0] ld_r;
  logic [N-1:0] ld_i;
  logic         start;
  logic         q_done;
  logic         busy, done, err, start_new_q;
  logic [3:0]   q_index;
  logic         H_in_valid, Y_in_valid;
  logic [N-1:0] H_in_r, H_in_i, Y_in_r, Y_in_i;

  int n_cmp = 0;
  int n_bad = 0;

  logic [N-1:0] h_r [16];
  logic [N-1:0] h_i [16];
  logic [N-1:0] y_r [8];
  logic [N-1:0] y_i [8];

  always #5 clk = ~clk;

  hy_stream_source #(
    .N(N),
    .NUM_Q(16),
    .TIMEOUT(1024)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .ld_valid(ld_valid),
    .ld_sel(ld_sel),
    .ld_addr(ld_addr),
    .ld_r(ld_r),
    .ld_i(ld_i),
    .start(start),
    .busy(busy),
    .done(done),
    .err(err),
    .start_new_q(start_new_q),
    .q_index(q_index),
    .H_in_valid(H_in_valid),
    .H_in_r(H_in_r),
    .H_in_i(H_in_i),
    .Y_in_valid(Y_in_valid),
    .Y_in_r(Y_in_r),
    .Y_in_i(Y_in_i),
    .q_done(q_done)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, {busy, done, err, start_new_q, H_in_valid, Y_in_valid, q_index}, '0);
    chk({tag, "_h"}, {H_in_r, H_in_i}, '0);
    chk({tag, "_y"}, {Y_in_r, Y_in_i}, '0);
  endtask

  task automatic chk_issue(input logic [3:0] q);
    chk("issue_ctl", {busy, start_new_q, H_in_valid, Y_in_valid, done}, 5'b11000);
    chk("issue_q", q_index, q);
  endtask

  // Checks beats 0..nb-1; pulses q_done at early_b and a busy-time load+start at ld_b.
  task automatic chk_beats(input logic [3:0] q, input int early_b, input int ld_b, input int nb);
    for (int b = 0; b < nb; b++) begin
      tick();
      q_done = (b == early_b);
      if (b == ld_b) begin
        ld_valid = 1'b1;
        ld_sel   = 1'b0;
        ld_addr  = 4'd0;
        ld_r     = 32'd7;
        ld_i     = 32'd7;
        start    = 1'b1;
      end else begin
        ld_valid = 1'b0;
        start    = 1'b0;
      end
      chk("h_beat", {H_in_valid, start_new_q, q_index}, {1'b1, 1'b0, q});
      chk("h_data", {H_in_r, H_in_i}, {h_r[b], h_i[b]});
      chk("y_beat", {Y_in_valid, Y_in_r, Y_in_i},
          (b < 8) ? {1'b1, y_r[b], y_i[b]} : 65'd0);
    end
  endtask

  // Enters WAIT_DONE, holds `delay` cycles, then exits (q_done pulsed if `pulse`).
  task automatic finish_wait(input logic [3:0] q, input int delay, input logic pulse, input logic last);
    tick();
    ld_valid = 1'b0;
    start    = 1'b0;
    q_done   = 1'b0;
    for (int d = 0; d < delay; d++) begin
      chk("wait_hold", {busy, done, start_new_q, H_in_valid, Y_in_valid, q_index}, {5'b10000, q});
      tick();
    end
    q_done = pulse;
    #1;
    chk("wait_done", {busy, done, err}, {1'b1, last, 1'b0});
    chk("wait_q", q_index, q);
    chk("wait_quiet", {H_in_valid, Y_in_valid, H_in_r, Y_in_r}, '0);
    tick();
    q_done = 1'b0;
    #1;
    if (last) chk("end_idle", {busy, done, start_new_q, q_index}, '0);
    else chk_issue(4'(q + 4'd1));
  endtask

  initial begin
    logic early;
    rst      = 1'b1;
    ld_valid = 1'b0;
    ld_sel   = 1'b0;
    ld_addr  = '0;
    ld_r     = '0;
    ld_i     = '0;
    start    = 1'b0;
    q_done   = 1'b0;
    for (int k = 0; k < 16; k++) begin
      h_r[k] = 32'(k);
      h_i[k] = 32'(-k);
    end
    for (int k = 0; k < 8; k++) begin
      y_r[k] = 32'h100 + 32'(k);
      y_i[k] = 32'h200 + 32'(k);
    end
    #1;
    chk_quiet("reset");
    tick();
    tick();
    rst = 1'b0;

    for (int k = 0; k < 16; k++) begin
      ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 4'(k); ld_r = 32'(k); ld_i = 32'(-k);
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 4'(k); ld_r = 32'h100 + 32'(k); ld_i = 32'h200 + 32'(k);
      tick();
    end
    ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 4'd9; ld_r = 32'hDEAD; ld_i = 32'hBEEF;
    tick();
    ld_valid = 1'b0;
    chk_quiet("idle_loaded");

    // Run A: 16 passes; pass 1 gets an early q_done, pass 3 sees a busy-time load and start.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_issue(4'd0);
    chk_beats(4'd0, -1, -1, 16);
    finish_wait(4'd0, 0, 1'b1, 1'b0);
    chk_beats(4'd1, 5, -1, 16);
    finish_wait(4'd1, 0, 1'b0, 1'b0);
    for (int p = 2; p < 15; p++) begin
      chk_beats(4'(p), -1, (p == 3) ? 2 : -1, 16);
      finish_wait(4'(p), 3, 1'b1, 1'b0);
    end
    chk_beats(4'd15, -1, -1, 16);
    finish_wait(4'd15, 0, 1'b1, 1'b1);
    chk("run_a_err", err, 1'b0);

    // Run B: q_done never returns.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_issue(4'd0);
    chk_beats(4'd0, -1, -1, 16);
    tick();
    ld_valid = 1'b0;
    start = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 1023; i++) begin
      if (done || err || !busy) early = 1'b1;
      tick();
    end
    chk("to_early", early, 1'b0);
    chk("to_fire", {busy, done, err}, 3'b111);
    tick();
    chk("to_idle", {busy, done, err, start_new_q, q_index}, 8'b0010_0000);

    // Run C: load and start together, then async reset at beat 6.
    ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 4'd3; ld_r = 32'h33; ld_i = -32'sh33;
    h_r[3] = 32'h33;
    h_i[3] = -32'sh33;
    start = 1'b1;
    tick();
    ld_valid = 1'b0;
    start = 1'b0;
    chk("err_cleared", err, 1'b0);
    chk_issue(4'd0);
    chk_beats(4'd0, -1, -1, 6);
    tick();
    ld_valid = 1'b0;
    start = 1'b0;
    chk("pre_rst_beat6", {H_in_valid, H_in_r}, {1'b1, h_r[6]});
    rst = 1'b1;
    #1;
    chk_quiet("async_rst");
    tick();
    rst = 1'b0;
    chk_quiet("post_rst");
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_issue(4'd0);
    chk_beats(4'd0, -1, -1, 16);
    rst = 1'b1;
    #1;
    chk_quiet("final_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
